// File: rtl/median_filter_pipe.sv
// median_filter_pipe
// ------------------
// Pipelined 3x3 window statistics filter for the image-denoising datapath.
// Each accepted window carries its own mode, so results come out in order and
// can be median, rounded mean, min or max, chosen window by window.
// A window accepted at edge N produces its result (wr=1) after edge N+3.
// The pipeline has four register ranks:
//   - input capture
//   - row sort and row sums
//   - cross-row reduction
//   - output select
// All four ranks freeze while en=0.
//
// Build option: define FILTER_ADAPTIVE_EN to make median mode impulse-adaptive.
// In that build the median replaces the centre pixel only when
// |centre - median| > THRESH; otherwise the centre passes through unchanged.
//
// Ports:
//   clk                      clock, all state on rising edge
//   rst                      asynchronous active-high reset
//   en                       pipeline advance enable (0 freezes every stage)
//   act                      input window valid, sampled when en=1
//   mode[1:0]                00 median, 01 mean, 10 min, 11 max
//   sw_pixels1..9[PIX_W]     window pixels, row-major, sw_pixels5 is the centre
//   wr                       one-cycle result valid pulse
//   cl_pixel[PIX_W]          filtered pixel, holds between results
//   done                     pulses together with the NPIX-th wr
//   out_cnt[CNT_W]           results emitted since reset or last done
module median_filter_pipe #(
  parameter int PIX_W  = 8,
  parameter int NPIX   = 65536,
  parameter int CNT_W  = 17,
  parameter int THRESH = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             act,
  input  logic [1:0]       mode,
  input  logic [PIX_W-1:0] sw_pixels1,
  input  logic [PIX_W-1:0] sw_pixels2,
  input  logic [PIX_W-1:0] sw_pixels3,
  input  logic [PIX_W-1:0] sw_pixels4,
  input  logic [PIX_W-1:0] sw_pixels5,
  input  logic [PIX_W-1:0] sw_pixels6,
  input  logic [PIX_W-1:0] sw_pixels7,
  input  logic [PIX_W-1:0] sw_pixels8,
  input  logic [PIX_W-1:0] sw_pixels9,
  output logic             wr,
  output logic [PIX_W-1:0] cl_pixel,
  output logic             done,
  output logic [CNT_W-1:0] out_cnt
);

  localparam int SUM_W = PIX_W + 4;
  localparam int ROW_W = PIX_W + 2;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NPIX - 1);
  localparam logic [PIX_W:0]   THRESH_V = (PIX_W+1)'(THRESH);

`ifdef FILTER_ADAPTIVE_EN
  localparam bit ADAPTIVE_EN = 1'b1;
`else
  localparam bit ADAPTIVE_EN = 1'b0;
`endif

  function automatic logic [PIX_W-1:0] fMin(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [PIX_W-1:0] fMax(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Median of three without a full sort; exact under ties.
  function automatic logic [PIX_W-1:0] fMed3(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b,
                                             input logic [PIX_W-1:0] c);
    return fMax(fMin(a, b), fMin(fMax(a, b), c));
  endfunction

  // Input capture rank
  logic [8:0][PIX_W-1:0] r0_pix;
  logic [1:0]            r0_mode;
  logic                  r0_vld;

  // Row-sorted rank
  logic [2:0][PIX_W-1:0] r1_lo, r1_mid, r1_hi;
  logic [2:0][ROW_W-1:0] r1_rowSum;
  logic [PIX_W-1:0]      r1_ctr;
  logic [1:0]            r1_mode;
  logic                  r1_vld;

  // Reduced rank
  logic [PIX_W-1:0] r2_maxLo, r2_medMid, r2_minHi, r2_gMin, r2_gMax, r2_ctr;
  logic [SUM_W-1:0] r2_sum;
  logic [1:0]       r2_mode;
  logic             r2_vld;

  logic [2:0][PIX_W-1:0] w_lo, w_mid, w_hi;
  logic [2:0][ROW_W-1:0] w_rowSum;
  logic [SUM_W-1:0]      w_sum, w_meanFull;
  logic [PIX_W-1:0]      w_mean, w_median, w_absDiff, w_medOut, w_result;
  logic                  w_impulse;

  // Sort each row into lo/mid/hi and form its sum.
  always_comb begin
    w_lo     = '0;
    w_mid    = '0;
    w_hi     = '0;
    w_rowSum = '0;
    for (int r = 0; r < 3; r++) begin
      w_lo[r]     = fMin(fMin(r0_pix[3*r], r0_pix[3*r+1]), r0_pix[3*r+2]);
      w_hi[r]     = fMax(fMax(r0_pix[3*r], r0_pix[3*r+1]), r0_pix[3*r+2]);
      w_mid[r]    = fMed3(r0_pix[3*r], r0_pix[3*r+1], r0_pix[3*r+2]);
      w_rowSum[r] = ROW_W'(r0_pix[3*r]) + ROW_W'(r0_pix[3*r+1]) + ROW_W'(r0_pix[3*r+2]);
    end
  end

  assign w_sum = SUM_W'(r1_rowSum[0]) + SUM_W'(r1_rowSum[1]) + SUM_W'(r1_rowSum[2]);

  // Classic 3x3 median network: median of (max of lows, median of mids, min of highs).
  assign w_median = fMed3(r2_maxLo, r2_medMid, r2_minHi);

  // Exact rounded mean; the upper quotient bits are always zero for a legal
  // sum, the saturation only exists so every quotient bit is accounted for.
  assign w_meanFull = (r2_sum + SUM_W'(4)) / SUM_W'(9);
  assign w_mean     = (|w_meanFull[SUM_W-1:PIX_W]) ? '1 : w_meanFull[PIX_W-1:0];

  // Impulse detector; only steers the output in the adaptive build.
  assign w_absDiff = (r2_ctr > w_median) ? (r2_ctr - w_median) : (w_median - r2_ctr);
  assign w_impulse = ({1'b0, w_absDiff} > THRESH_V);
  assign w_medOut  = (!ADAPTIVE_EN || w_impulse) ? w_median : r2_ctr;

  always_comb begin
    w_result = w_medOut;
    case (r2_mode)
      2'b00:   w_result = w_medOut;
      2'b01:   w_result = w_mean;
      2'b10:   w_result = r2_gMin;
      default: w_result = r2_gMax;
    endcase
  end

  // Datapath ranks; every rank advances only on en, so a stall freezes the
  // whole pipe and a resumed pipe continues exactly where it stopped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r0_pix    <= '0;
      r0_mode   <= '0;
      r0_vld    <= 1'b0;
      r1_lo     <= '0;
      r1_mid    <= '0;
      r1_hi     <= '0;
      r1_rowSum <= '0;
      r1_ctr    <= '0;
      r1_mode   <= '0;
      r1_vld    <= 1'b0;
      r2_maxLo  <= '0;
      r2_medMid <= '0;
      r2_minHi  <= '0;
      r2_gMin   <= '0;
      r2_gMax   <= '0;
      r2_ctr    <= '0;
      r2_sum    <= '0;
      r2_mode   <= '0;
      r2_vld    <= 1'b0;
    end else if (en) begin
      r0_pix    <= {sw_pixels9, sw_pixels8, sw_pixels7, sw_pixels6, sw_pixels5,
                    sw_pixels4, sw_pixels3, sw_pixels2, sw_pixels1};
      r0_mode   <= mode;
      r0_vld    <= act;
      r1_lo     <= w_lo;
      r1_mid    <= w_mid;
      r1_hi     <= w_hi;
      r1_rowSum <= w_rowSum;
      r1_ctr    <= r0_pix[4];
      r1_mode   <= r0_mode;
      r1_vld    <= r0_vld;
      r2_maxLo  <= fMax(fMax(r1_lo[0], r1_lo[1]), r1_lo[2]);
      r2_medMid <= fMed3(r1_mid[0], r1_mid[1], r1_mid[2]);
      r2_minHi  <= fMin(fMin(r1_hi[0], r1_hi[1]), r1_hi[2]);
      r2_gMin   <= fMin(fMin(r1_lo[0], r1_lo[1]), r1_lo[2]);
      r2_gMax   <= fMax(fMax(r1_hi[0], r1_hi[1]), r1_hi[2]);
      r2_ctr    <= r1_ctr;
      r2_sum    <= w_sum;
      r2_mode   <= r1_mode;
      r2_vld    <= r1_vld;
    end
  end

  // Output rank and frame counter: cl_pixel only changes on a real result,
  // and the NPIX-th result wraps the counter and raises done in one update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr       <= 1'b0;
      done     <= 1'b0;
      cl_pixel <= '0;
      out_cnt  <= '0;
    end else if (!en) begin
      wr   <= 1'b0;
      done <= 1'b0;
    end else begin
      wr   <= r2_vld;
      done <= 1'b0;
      if (r2_vld) begin
        cl_pixel <= w_result;
        if (out_cnt == LAST_CNT) begin
          out_cnt <= '0;
          done    <= 1'b1;
        end else begin
          out_cnt <= out_cnt + 1'b1;
        end
      end
    end
  end

endmodule
